// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock with a registered carry.
// Optional subtract support is enabled by defining DSA_SUB_EN.
module digit_serial_adder #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] y_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] y_eff;
   logic             carry;
   logic             carry_init;
   logic             x_msb;
   logic             y_msb;
   logic             ovf_reg;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   digit_add;
   logic             accept;
   logic             last_digit;

`ifdef DSA_SUB_EN
   // Subtraction is x + ~y + 1, so c_out = 1 means no borrow.
   assign y_eff      = sub ? ~y : y;
   assign carry_init = sub ? 1'b1 : c_in;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign y_eff      = y;
   assign carry_init = c_in;
`endif

   assign digit_add  = {1'b0, x_reg[DIGIT-1:0]} + {1'b0, y_reg[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
   assign accept     = in_valid && in_ready;
   assign last_digit = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_digit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands drain out of the bottom while result digits fill the sum register from the top;
   // the widened shifts stay legal even when a single digit covers the whole word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg   <= '0;
         y_reg   <= '0;
         sum_reg <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         x_msb   <= 1'b0;
         y_msb   <= 1'b0;
         ovf_reg <= 1'b0;
      end else if (accept) begin
         x_reg   <= x;
         y_reg   <= y_eff;
         carry   <= carry_init;
         cnt     <= '0;
         x_msb   <= x[WIDTH-1];
         y_msb   <= y_eff[WIDTH-1];
         ovf_reg <= 1'b0;
      end else if (state == RUN) begin
         sum_reg <= WIDTH'({digit_add[DIGIT-1:0], sum_reg} >> DIGIT);
         x_reg   <= WIDTH'({{DIGIT{1'b0}}, x_reg} >> DIGIT);
         y_reg   <= WIDTH'({{DIGIT{1'b0}}, y_reg} >> DIGIT);
         carry   <= digit_add[DIGIT];
         cnt     <= cnt + CW'(1);
         if (last_digit) begin
            ovf_reg <= (x_msb == y_msb) && (digit_add[DIGIT-1] != x_msb);
         end
      end
   end

   assign s     = sum_reg;
   assign c_out = carry;
   assign ovf   = ovf_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: expected results come from a plain-arithmetic model.
// Also exercises the N=1 and N=32 configurations directly.
module tb_digit_serial_adder;

   localparam int WIDTH = 32;
   localparam int DIGIT = 8;
   localparam int N     = WIDTH / DIGIT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic        c_in = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] s;
   logic        c_out;
   logic        ovf;

   logic        sw_valid = 1'b0;
   logic [31:0] sw_x = '0;
   logic [31:0] sw_y = '0;
   logic        sw_cin = 1'b0;
   logic        sw_sub = 1'b0;
   logic        sw_out_ready = 1'b1;
   logic        rdy1, rdy32, ov1, ov32, co1, co32, of1, of32;
   logic [31:0] s1, s32;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          t;
   } exp_t;

   exp_t sb[$];
   exp_t head;
   bit   seen = 1'b0;

   digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .c_in(c_in), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
   );

   digit_serial_adder #(.WIDTH(32), .DIGIT(32)) dut_n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy1),
      .x(sw_x), .y(sw_y), .c_in(sw_cin), .sub(sw_sub), .out_valid(ov1),
      .out_ready(sw_out_ready), .s(s1), .c_out(co1), .ovf(of1)
   );

   digit_serial_adder #(.WIDTH(32), .DIGIT(1)) dut_n32 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy32),
      .x(sw_x), .y(sw_y), .c_in(sw_cin), .sub(sw_sub), .out_valid(ov32),
      .out_ready(sw_out_ready), .s(s32), .c_out(co32), .ovf(of32)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Returns {ovf, c_out, s} for one operation.
   function automatic logic [33:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic do_sub);
      logic [31:0] b_eff;
      logic        cin_eff;
      logic [32:0] total;
      b_eff   = b;
      cin_eff = ci;
`ifdef DSA_SUB_EN
      if (do_sub) begin
         b_eff   = ~b;
         cin_eff = 1'b1;
      end
`else
      if (do_sub) begin
         b_eff = b;
      end
`endif
      total = {1'b0, a} + {1'b0, b_eff} + {32'd0, cin_eff};
      return {(a[31] == b_eff[31]) && (total[31] != a[31]), total[32], total[31:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic ci, input logic do_sub);
      logic [33:0] r;
      int          guard;
      guard    = 0;
      in_valid = 1'b1;
      x        = a;
      y        = b;
      c_in     = ci;
      sub      = do_sub;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      r = refModel(a, b, ci, do_sub);
      sb.push_back('{r[31:0], r[32], r[33], cyc + 1});
      tick();
      in_valid = 1'b0;
      x        = $urandom;
      y        = $urandom;
      c_in     = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
   endtask

   task automatic drain(input bit random_bp);
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         if (random_bp) out_ready = ($urandom_range(0, 3) != 0);
         tick();
         guard++;
      end
      out_ready = 1'b1;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: latency is checked on the first cycle a result is shown, values when it is taken.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_out_valid: out_valid=1 with no operation pending");
         end else begin
            if (!seen) begin
               checkOutput("latency", 64'(cyc - sb[0].t), 64'(N));
               seen = 1'b1;
            end
            if (out_ready) begin
               head = sb.pop_front();
               checkOutput("sum", 64'(s), 64'(head.s));
               checkOutput("c_out", 64'(c_out), 64'(head.c));
               checkOutput("ovf", 64'(ovf), 64'(head.o));
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [33:0] r;
      int          t0;
      int          guard;
      bit          got1, got32;

      #3;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_s", 64'(s), 64'd0);
      checkOutput("rst_c_out", 64'(c_out), 64'd0);
      checkOutput("rst_ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drain(1'b0);
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drain(1'b0);
      applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
      drain(1'b0);

      out_ready = 1'b0;
      applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      guard = 0;
      while (!out_valid && guard < 20) begin
         tick();
         guard++;
      end
      repeat (10) begin
         @(negedge clk);
         checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
         checkOutput("bp_s", 64'(s), 64'h2345_6789);
         checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      end
      tick();
      out_ready = 1'b1;
      tick();
      checkOutput("release_out_valid", 64'(out_valid), 64'd0);
      checkOutput("release_in_ready", 64'(in_ready), 64'd1);
      drain(1'b0);

      checkOutput("sweep_n1_ready", 64'(rdy1), 64'd1);
      checkOutput("sweep_n32_ready", 64'(rdy32), 64'd1);
      sw_x     = 32'hA5A5_A5A5;
      sw_y     = 32'h5A5A_5A5A;
      sw_cin   = 1'b1;
      sw_valid = 1'b1;
      t0       = cyc + 1;
      r        = refModel(sw_x, sw_y, sw_cin, 1'b0);
      tick();
      sw_valid = 1'b0;
      got1     = 1'b0;
      got32    = 1'b0;
      guard    = 0;
      while (!(got1 && got32) && guard < 40) begin
         @(negedge clk);
         guard++;
         if (ov1 && !got1) begin
            got1 = 1'b1;
            checkOutput("n1_latency", 64'(cyc - t0), 64'd1);
            checkOutput("n1_sum", 64'(s1), 64'(r[31:0]));
            checkOutput("n1_c_out", 64'(co1), 64'(r[32]));
            checkOutput("n1_ovf", 64'(of1), 64'(r[33]));
         end
         if (ov32 && !got32) begin
            got32 = 1'b1;
            checkOutput("n32_latency", 64'(cyc - t0), 64'd32);
            checkOutput("n32_sum", 64'(s32), 64'(r[31:0]));
            checkOutput("n32_c_out", 64'(co32), 64'(r[32]));
            checkOutput("n32_ovf", 64'(of32), 64'(r[33]));
         end
      end
      checkOutput("sweep_done", 64'({got1, got32}), 64'b11);
      tick();
      tick();

      applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
      repeat (8) tick();
      applyStimulus(32'd3, 32'd4, 1'b0, 1'b0);
      drain(1'b0);

      for (int i = 0; i < 30; i++) begin
         applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
         drain(1'b1);
      end

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
